// File: rtl/pg_alu_domain.sv
// pg_alu_domain
//   Power-gated WIDTH-bit ALU with a shift-add multiplier. An on-chip
//   sequencer steps the domain through ON -> ISO -> SAVE -> OFF ->
//   PWRUP -> RESTORE -> ON. It drives the isolation and supply-enable
//   controls itself.
//
//   Optional feature macro: PG_ALU_RETENTION_EN
//     defined   : SAVE copies the result into a retention register and
//                 RESTORE reloads it, so the result survives power-down.
//     undefined : no retention register; the result reads 0 after wake.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   A, B, opcode      operands / operation, sampled on an accepted start
//   start             request, accepted in ON while not busy
//   sleep_req         level request to power down (honoured in ON only)
//   wake_req          level request to power up (honoured in OFF only)
//   result            result register, or CLAMP_VAL while isolated
//   valid             one-cycle pulse when a new result is written
//   busy              multiply in progress
//   iso_en            isolation control (registered)
//   alu_pwr_en        domain supply enable (registered)
//   pwr_state         sequencer state code
//   clamp_obs         constant CLAMP_VAL
module pg_alu_domain #(
  parameter int               WIDTH         = 16,
  parameter logic [WIDTH-1:0] CLAMP_VAL     = {WIDTH{1'b0}},
  parameter int               PWR_UP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  input  logic             start,
  input  logic             sleep_req,
  input  logic             wake_req,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             iso_en,
  output logic             alu_pwr_en,
  output logic [2:0]       pwr_state,
  output logic [WIDTH-1:0] clamp_obs
);

  localparam int               MC_W     = $clog2(WIDTH);
  localparam int               CNT_W    = (PWR_UP_CYCLES > 1) ? $clog2(PWR_UP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PWR_UP_CYCLES - 1);
  localparam logic [MC_W-1:0]  MC_LOAD  = MC_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V  = WIDTH'(WIDTH);
  localparam logic [3:0]       OP_MUL   = 4'd7;

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_ISO     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_OFF     = 3'd3,
    ST_PWRUP   = 3'd4,
    ST_RESTORE = 3'd5
  } pwr_state_t;

  pwr_state_t       state, state_n;
  logic [CNT_W-1:0] pwr_cnt;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [MC_W-1:0]  mcnt;
  logic             accept;

  // Single-cycle operations; MUL is handled by the iterative datapath.
  function automatic logic [WIDTH-1:0] alu_op(input logic [3:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] sh;
    sh = b % WIDTH_V;
    case (op)
      4'd0:    alu_op = a + b;
      4'd1:    alu_op = a - b;
      4'd2:    alu_op = a & b;
      4'd3:    alu_op = a | b;
      4'd4:    alu_op = a ^ b;
      4'd5:    alu_op = a << sh;
      4'd6:    alu_op = a >> sh;
      default: alu_op = '0;
    endcase
  endfunction

  assign accept  = (state == ST_ON) && !busy && start;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Sequencer: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_ON;
      iso_en     <= 1'b0;
      alu_pwr_en <= 1'b1;
      pwr_cnt    <= '0;
    end else begin
      state      <= state_n;
      // Controls are registered from the next state so they line up with pwr_state.
      iso_en     <= (state_n != ST_ON);
      alu_pwr_en <= (state_n != ST_OFF);
      if (state == ST_OFF && wake_req)
        pwr_cnt <= CNT_LOAD;
      else if (state == ST_PWRUP && pwr_cnt != '0)
        pwr_cnt <= pwr_cnt - 1'b1;
    end
  end

  // Sequencer: next-state logic
  always_comb begin
    state_n = state;
    case (state)
      // A start in the same cycle as sleep_req wins; sleep waits for !busy.
      ST_ON:      if (sleep_req && !busy && !start) state_n = ST_ISO;
      ST_ISO:     state_n = ST_SAVE;
      ST_SAVE:    state_n = ST_OFF;
      ST_OFF:     if (wake_req) state_n = ST_PWRUP;
      ST_PWRUP:   if (pwr_cnt == '0) state_n = ST_RESTORE;
      ST_RESTORE: state_n = ST_ON;
      default:    state_n = ST_ON;
    endcase
  end

`ifdef PG_ALU_RETENTION_EN
  logic [WIDTH-1:0] ret_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ret_q <= '0;
    else if (state == ST_SAVE)
      ret_q <= res_q;
  end
`endif

  // Result register and multiplier control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      mcnt  <= '0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        if (opcode == OP_MUL) begin
          busy <= 1'b1;
          mcnt <= MC_LOAD;
        end else begin
          res_q <= alu_op(opcode, A, B);
          valid <= 1'b1;
        end
      end else if (busy) begin
        if (mcnt == '0) begin
          res_q <= acc_nxt;
          valid <= 1'b1;
          busy  <= 1'b0;
        end else begin
          mcnt <= mcnt - 1'b1;
        end
      end else if (state == ST_OFF) begin
        res_q <= '0;
`ifdef PG_ALU_RETENTION_EN
      end else if (state == ST_RESTORE) begin
        res_q <= ret_q;
`endif
      end
    end
  end

  // Shift-add datapath: one multiplier bit per busy cycle, LSB first
  always_ff @(posedge clk) begin
    if (accept && opcode == OP_MUL) begin
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
    end else if (busy) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
    end
  end

  assign result    = iso_en ? CLAMP_VAL : res_q;
  assign pwr_state = state;
  assign clamp_obs = CLAMP_VAL;

endmodule

// File: tb/tb_pg_alu_domain.sv
module tb_pg_alu_domain;

  localparam int          WIDTH = 16;
  localparam logic [15:0] CLAMP = 16'hC1A5;
  localparam int          PUC   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A, B;
  logic [3:0]  opcode;
  logic        start, sleep_req, wake_req;
  logic [15:0] result, clamp_obs;
  logic        valid, busy, iso_en, alu_pwr_en;
  logic [2:0]  pwr_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pg_alu_domain #(
    .WIDTH(WIDTH), .CLAMP_VAL(CLAMP), .PWR_UP_CYCLES(PUC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .opcode(opcode), .start(start),
    .sleep_req(sleep_req), .wake_req(wake_req), .result(result), .valid(valid),
    .busy(busy), .iso_en(iso_en), .alu_pwr_en(alu_pwr_en),
    .pwr_state(pwr_state), .clamp_obs(clamp_obs)
  );

  always #5 clk = ~clk;

  // Behavioural model: 0 ON, 1 ISO, 2 SAVE, 3 OFF, 4 PWRUP, 5 RESTORE
  int          m_state;
  logic [15:0] m_res, m_ret, m_mul_val;
  logic        m_valid, m_busy;
  int          m_mul_left, m_pu_left;

  function automatic logic [15:0] ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'(b) % WIDTH;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << s;
      4'd6:    return a >> s;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_update();
    bit go_iso;
    if (!rst_n) begin
      m_state = 0; m_res = 0; m_ret = 0; m_valid = 0; m_busy = 0;
      m_mul_left = 0; m_pu_left = 0;
      return;
    end
    m_valid = 0;
    case (m_state)
      0: begin
        go_iso = sleep_req && !m_busy && !start;
        if (start && !m_busy) begin
          if (opcode == 4'd7) begin
            m_busy = 1;
            m_mul_left = WIDTH;
            m_mul_val = 16'((32'(A) * 32'(B)) & 32'hFFFF);
          end else begin
            m_res = ref_op(opcode, A, B);
            m_valid = 1;
          end
        end else if (m_busy) begin
          m_mul_left--;
          if (m_mul_left == 0) begin
            m_res = m_mul_val; m_valid = 1; m_busy = 0;
          end
        end
        if (go_iso) m_state = 1;
      end
      1: m_state = 2;
      2: begin
`ifdef PG_ALU_RETENTION_EN
        m_ret = m_res;
`endif
        m_state = 3;
      end
      3: begin
        m_res = 0;
        if (wake_req) begin m_state = 4; m_pu_left = PUC; end
      end
      4: begin
        m_pu_left--;
        if (m_pu_left == 0) m_state = 5;
      end
      default: begin
`ifdef PG_ALU_RETENTION_EN
        m_res = m_ret;
`endif
        m_state = 0;
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("pwr_state",  32'(pwr_state), 32'(m_state));
    chk("result",     32'(result), 32'((m_state != 0) ? CLAMP : m_res));
    chk("valid",      32'(valid), 32'(m_valid));
    chk("busy",       32'(busy), 32'(m_busy));
    chk("iso_en",     32'(iso_en), 32'(m_state != 0));
    chk("alu_pwr_en", 32'(alu_pwr_en), 32'(m_state != 3));
    chk("clamp_obs",  32'(clamp_obs), 32'(CLAMP));
  endtask

  // Inputs change only after the negedge compare; the model consumes them at posedge.
  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    start = 1; opcode = op; A = a; B = b;
    step();
    start = 0;
  endtask

  initial begin
    int bc, pc;
    bit got;
    rst_n = 0; A = 0; B = 0; opcode = 0; start = 0; sleep_req = 0; wake_req = 0;
    @(negedge clk);
    step(); step();
    chk("reset_state", 32'(pwr_state), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    rst_n = 1;
    step();

    // ADD wraps
    issue(4'd0, 16'hFFFF, 16'h0002);
    chk("add_lit", 32'(result), 32'h0001);
    chk("add_valid", 32'(valid), 32'd1);
    step();
    chk("add_valid_drop", 32'(valid), 32'd0);

    // MUL with an ignored start while busy
    issue(4'd7, 16'h0012, 16'h0034);
    bc = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (valid) got = 1;
      else begin
        if (busy) bc++;
        start = (i == 3); opcode = 4'd0; A = 16'h0001; B = 16'h0001;
        step();
      end
    end
    start = 0;
    chk("mul_done", 32'(got), 32'd1);
    chk("mul_busy_cycles", 32'(bc), 32'd16);
    chk("mul_lit", 32'(result), 32'h03A8);

    // Random single-cycle and MUL traffic, no power events
    for (int i = 0; i < 300; i++) begin
      start = ($urandom_range(0, 2) == 0);
      opcode = 4'($urandom_range(0, 15));
      A = 16'($urandom); B = 16'($urandom);
      step();
    end
    start = 0;
    for (int i = 0; i < 20 && busy; i++) step();

    // Power-down sequence with a retained value
    issue(4'd0, 16'h1234, 16'h0000);
    chk("pre_sleep_lit", 32'(result), 32'h1234);
    sleep_req = 1;
    step();
    chk("iso_code", 32'(pwr_state), 32'd1);
    chk("iso_clamp", 32'(result), 32'(CLAMP));
    step();
    chk("save_code", 32'(pwr_state), 32'd2);
    step();
    chk("off_code", 32'(pwr_state), 32'd3);
    chk("off_pwr", 32'(alu_pwr_en), 32'd0);
    sleep_req = 0;
    issue(4'd0, 16'h0001, 16'h0001);
    chk("off_no_valid", 32'(valid), 32'd0);
    step();

    // Power-up
    wake_req = 1;
    step();
    wake_req = 0;
    pc = 0;
    for (int i = 0; i < 20 && pwr_state == 3'd4; i++) begin pc++; step(); end
    chk("pwrup_cycles", 32'(pc), 32'(PUC));
    chk("restore_code", 32'(pwr_state), 32'd5);
    step();
    chk("on_code", 32'(pwr_state), 32'd0);
`ifdef PG_ALU_RETENTION_EN
    chk("restore_lit", 32'(result), 32'h1234);
`else
    chk("restore_lit", 32'(result), 32'h0000);
`endif

    // Sleep and MUL start together: multiply finishes first
    sleep_req = 1;
    issue(4'd7, 16'h0101, 16'h0003);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (valid) got = 1; else step();
    end
    chk("sm_done", 32'(got), 32'd1);
    chk("sm_lit", 32'(result), 32'h0303);
    chk("sm_still_on", 32'(pwr_state), 32'd0);
    step();
    chk("sm_iso", 32'(pwr_state), 32'd1);
    sleep_req = 0;
    step(); step();
    wake_req = 1;
    step();
    wake_req = 0;
    step();
    chk("pre_rst_pwrup", 32'(pwr_state), 32'd4);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("rst_pwrup_state", 32'(pwr_state), 32'd0);
    chk("rst_pwrup_iso", 32'(iso_en), 32'd0);
    chk("rst_pwrup_pwr", 32'(alu_pwr_en), 32'd1);
    chk("rst_pwrup_result", 32'(result), 32'd0);

    // Random traffic with power events and occasional reset
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      opcode = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
      A = 16'($urandom); B = 16'($urandom);
      sleep_req = ($urandom_range(0, 25) == 0);
      wake_req = ($urandom_range(0, 6) == 0);
      rst_n = ($urandom_range(0, 400) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pg_alu_domain.md
# pg_alu_domain

Power-gated, parametrised ALU domain: a WIDTH-bit ALU with a multi-cycle multiplier, wrapped by an on-chip power-sequencing FSM that drives its own isolation and power-enable controls. It also provides a retention register so the last result survives a power-down/power-up cycle. It sits between the core datapath and the always-on domain, replacing the externally driven power-enable/isolation arrangement of the previous top-level ALU.

## Interface
- WIDTH, 16: operand/result width (≥4).
- CLAMP_VAL, {WIDTH{1'b0}}: value driven on `result` whenever isolation is active.
- PWR_UP_CYCLES, 4: cycles spent in PWRUP for supply settling (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- A, B  in  WIDTH  operands, sampled on accepted `start`.
- opcode  in  4  operation, sampled on accepted `start`.
- start  in  1  one-cycle request; accepted only when pwr_state==ON and !busy.
- sleep_req  in  1  level request to power down.
- wake_req  in  1  level request to power up.
- result  out  WIDTH  ALU result register, or CLAMP_VAL while iso_en.
- valid  out  1  one-cycle pulse when a new result is written.
- busy  out  1  multiply in progress.
- iso_en  out  1  isolation control (registered).
- alu_pwr_en  out  1  domain supply enable (registered).
- pwr_state  out  3  FSM state code.
- clamp_obs  out  WIDTH  constant CLAMP_VAL, for observation.

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by B mod WIDTH, 6 SHR logical by B mod WIDTH, 7 MUL (low WIDTH bits, shift-add), 8–15 result 0.
- ADD/SUB wrap modulo 2^WIDTH; no flags.
- FSM codes: ON=0, ISO=1, SAVE=2, OFF=3, PWRUP=4, RESTORE=5.
- ON: iso_en=0, alu_pwr_en=1.
  - Goes to ISO when sleep_req && !busy && !start.
  - If start and sleep_req are high in the same cycle, start wins. Sleep is taken once the op completes, if sleep_req is still high.
- ISO: iso_en=1. Goes to SAVE next cycle.
- SAVE: retention register ← internal result. Goes to OFF next cycle.
- OFF: alu_pwr_en=0 and the internal result register is cleared to 0. Stays in OFF until wake_req.
- PWRUP: alu_pwr_en=1. A down-counter loads PWR_UP_CYCLES−1 on entry; when it reaches 0, goes to RESTORE.
- RESTORE: internal result ← retention register. Goes to ON; iso_en falls on that transition.
- iso_en is 1 in ISO, SAVE, OFF, PWRUP and RESTORE.
- sleep_req is ignored outside ON.
- wake_req is ignored outside OFF; it does not abort ISO or SAVE.
- start is ignored outside ON, and ignored while busy.
- valid never pulses outside ON. A restore does not pulse valid.

## Timing
- Reset (rst_n=0 at a rising edge), from any state, including mid-multiply or mid-sequence:
  - pwr_state=ON, iso_en=0, alu_pwr_en=1.
  - result=0, retention=0, valid=0, busy=0, counter cleared.
- Single-cycle ops: start accepted at edge N; result and valid=1 at edge N+1.
- MUL:
  - busy=1 from edge N+1 through edge N+WIDTH.
  - result and valid at edge N+WIDTH+1; busy=0 in that same cycle.
  - The next start may be accepted in that cycle.
- Power-down from ON with sleep_req: ISO at +1, SAVE at +2, OFF at +3.
- Power-up from OFF with wake_req:
  - PWRUP at +1.
  - RESTORE at +1+PWR_UP_CYCLES.
  - ON at +2+PWR_UP_CYCLES; first start can be accepted in that cycle.
- result output is combinational from iso_en and the internal register: it shows CLAMP_VAL from the cycle iso_en rises.

## Configuration
- PG_ALU_RETENTION_EN defined:
  - SAVE captures the result into the retention register.
  - RESTORE reloads it, so after wake `result` equals the pre-sleep value.
- PG_ALU_RETENTION_EN undefined:
  - No retention register is built.
  - SAVE and RESTORE are still traversed with the same timing, but do nothing to the data.
  - After wake, result=0.

## Test plan
- Reset, then ADD A=0xFFFF B=0x0002 (WIDTH=16) → next cycle result=0x0001, valid=1 for one cycle.
- MUL A=0x0012 B=0x0034 → busy high for 16 cycles, then result=0x03A8 with valid. A start issued while busy is ignored.
- Result 0x1234, then sleep_req → state codes 1, 2, 3 on consecutive cycles. result=CLAMP_VAL from ISO onward, alu_pwr_en=0 in OFF. start in OFF gives no valid.
- Wake_req from OFF (PWR_UP_CYCLES=4) → PWRUP for 4 cycles, RESTORE, then ON. result=0x1234 with PG_ALU_RETENTION_EN defined, 0x0000 without.
- sleep_req asserted with MUL start in the same cycle → multiply completes with valid, then ISO the next cycle.
- rst_n low during PWRUP → next cycle ON, iso_en=0, alu_pwr_en=1, result=0.
